wb_commit_unit: RTL and testbench
=================================

# wb_commit_unit

Write-back commit unit: the write-side companion of the 32x32 register file. It accepts results from the ALU and the load/store unit over valid/ready handshakes and arbitrates them round-robin. Results are buffered in a small in-order FIFO and drive the register file's `write`/`w_addr`/`w_data` port one result per cycle. An optional pending-write scoreboard lets decode stall on RAW hazards.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of 2, at least 2.
- `CW`, 3: count width, equal to log2(DEPTH)+1.

Ports:
- `clk` in 1: clock.
- `rstn` in 1: reset; asynchronous, active-low.
- `alu_valid` in 1: ALU result valid.
- `alu_ready` out 1: ALU result accepted this cycle.
- `alu_rd` in 5: ALU destination register.
- `alu_data` in 32: ALU result.
- `lsu_valid` in 1: load result valid.
- `lsu_ready` out 1: load result accepted this cycle.
- `lsu_rd` in 5: load destination register.
- `lsu_data` in 32: load data.
- `wb_hold` in 1: freeze FIFO drain (debug halt).
- `issue_valid` in 1: decode issued an instruction that writes `issue_rd`.
- `issue_rd` in 5: destination of the issued instruction.
- `rs1_addr` in 5: decode source 1 address.
- `rs2_addr` in 5: decode source 2 address.
- `rs1_busy` out 1: source 1 has a pending write.
- `rs2_busy` out 1: source 2 has a pending write.
- `rf_write` out 1: register-file write strobe (registered).
- `rf_w_addr` out 5: register-file write address (registered).
- `rf_w_data` out 32: register-file write data (registered).
- `fifo_count` out CW: occupied FIFO entries.

## Operation
- Arbitration:
  - Only one source is granted per cycle.
  - If only one valid is asserted and the FIFO is not full, that source is granted.
  - If both are valid, grant follows a round-robin pointer: reset points to ALU; after a contested grant, the pointer moves to the other source.
  - An uncontested grant does not move the pointer.
- `x_ready` is combinational: it equals grant AND (`fifo_count` < DEPTH).
- A transfer completes when `x_valid` and `x_ready` are both high. Sources must hold rd and data stable until ready.
- x0 filter: an accepted result with rd==0 completes its handshake but is not pushed, not written, and not counted.
- FIFO: circular buffer with wrapping read/write pointers.
  - A push and pop in the same cycle leave the count unchanged.
  - A push into an empty FIFO is legal in the same cycle a pop would have occurred; there is no bypass, so the new entry pops next cycle.
- Drain:
  - Each cycle with the FIFO non-empty and `wb_hold` low, the head pops into the `rf_*` registers and `rf_write` is set to 1.
  - Otherwise `rf_write` is set to 0. `rf_w_addr`/`rf_w_data` hold their last values.
- Scoreboard: 32-bit `pending` vector; bit 0 is constant 0.
  - Set on `issue_valid` with `issue_rd`!=0.
  - Cleared at the edge where `rf_write` is high for `rf_w_addr`, i.e. the same edge the register file updates.
  - Simultaneous set and clear of the same bit: set wins.
  - `rsN_busy` = `pending[rsN_addr]`, combinational.
- Decode must not issue to an rd that is already pending (WAW); this unit does not check for it.

## Timing
- Reset values:
  - `rf_write`, `rf_w_addr`, `rf_w_data`, `fifo_count`: all 0.
  - FIFO empty; pointers 0; round-robin pointer on ALU; `pending` all 0.
  - `alu_ready`/`lsu_ready` go high as soon as their valid is high after reset.
- Latency: a result accepted at edge E is popped at edge E+1, drives `rf_write` during cycle E+1, and the register-file array updates at edge E+2.
- Throughput: 1 result/cycle sustained. At most one source is accepted per cycle, so contested sources alternate.
- Full: at `fifo_count`==DEPTH both readies are low, even if a pop occurs in the same cycle; there is no full-pass-through.
- `wb_hold`:
  - Freezes the pop only.
  - Acceptance continues until the FIFO is full.
  - Releasing `wb_hold` resumes the drain on the next edge.
- Reset mid-operation: FIFO contents and pending bits are discarded; no partial write is issued.

## Configuration
- `WB_SCOREBOARD_EN` defined: the `pending` vector and busy logic are built as described.
- Undefined: no scoreboard flops; `rs1_busy`/`rs2_busy` are tied to 0; `issue_valid`/`issue_rd` are ignored.

## Test plan
- Reset, then a single ALU result rd=5, data=0xDEADBEEF: `alu_ready` is 1 in the same cycle; two edges later `rf_write`=1, `rf_w_addr`=5, `rf_w_data`=0xDEADBEEF; `fifo_count` returns to 0.
- ALU and LSU both valid for 4 cycles (ALU rd=1..4, LSU rd=11..14): grants alternate ALU, LSU, ALU, LSU starting with ALU; writes appear in grant order at 1/cycle.
- `wb_hold`=1, then 5 ALU results with DEPTH=4: 4 accepted, 5th sees `alu_ready`=0 and `fifo_count`=4; release hold → 4 writes in order, then the 5th is accepted.
- LSU result with rd=0, data=0x1234: handshake completes, `fifo_count` stays 0, `rf_write` never asserts.
- Scoreboard (macro defined): issue rd=7 → `rs1_busy`=1 for `rs1_addr`=7. An ALU result for rd=7 clears the bit at the edge `rf_write` is high. Issuing rd=7 on that same edge keeps the bit set.
- Assert `rstn` low while 3 entries are queued and 2 bits are pending: all outputs 0 immediately; after release, no `rf_write` occurs.

Source files
------------

// File: rtl/wb_commit_unit.sv
// wb_commit_unit
//
// Write-back commit unit that sits in front of the 32x32 register file write port.
// ALU and load/store results arrive over valid/ready handshakes. A round-robin
// arbiter grants at most one of them per cycle. Granted results go into a small
// in-order FIFO. The FIFO drains one entry per cycle into the registered
// rf_write / rf_w_addr / rf_w_data outputs.
//
// Optional feature macro: WB_SCOREBOARD_EN.
// When it is defined, a pending-write vector is built. Decode sets a bit on issue
// and the register-file write clears it, which drives rs1_busy / rs2_busy.
// When it is undefined, there are no scoreboard flops and both busy outputs are 0.
//
// Parameters:
//   DEPTH      FIFO entries (power of 2, >= 2)
//   CW         count width, log2(DEPTH)+1
//
// Ports:
//   clk, rstn                          clock; asynchronous active-low reset
//   alu_valid/alu_ready/alu_rd/alu_data  ALU result channel
//   lsu_valid/lsu_ready/lsu_rd/lsu_data  load result channel
//   wb_hold                            freezes the FIFO drain only
//   issue_valid/issue_rd               decode issued a writer of issue_rd
//   rs1_addr/rs2_addr                  decode source addresses
//   rs1_busy/rs2_busy                  source has a pending write
//   rf_write/rf_w_addr/rf_w_data       registered register-file write port
//   fifo_count                         occupied FIFO entries
//
// Handshake: a transfer happens on a rising edge where x_valid and x_ready are
// both high. x_ready is combinational (grant AND not full) and never waits on
// anything except the arbiter and occupancy. A source holds rd/data stable
// while valid is high and ready is low.
module wb_commit_unit #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          alu_valid,
    output logic          alu_ready,
    input  logic [4:0]    alu_rd,
    input  logic [31:0]   alu_data,
    input  logic          lsu_valid,
    output logic          lsu_ready,
    input  logic [4:0]    lsu_rd,
    input  logic [31:0]   lsu_data,
    input  logic          wb_hold,
    input  logic          issue_valid,
    input  logic [4:0]    issue_rd,
    input  logic [4:0]    rs1_addr,
    input  logic [4:0]    rs2_addr,
    output logic          rs1_busy,
    output logic          rs2_busy,
    output logic          rf_write,
    output logic [4:0]    rf_w_addr,
    output logic [31:0]   rf_w_data,
    output logic [CW-1:0] fifo_count
);

    localparam int AW = $clog2(DEPTH);

    logic [4:0]    mem_rd   [DEPTH];
    logic [31:0]   mem_data [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Round-robin pointer: 0 = ALU has priority on a contested cycle, 1 = LSU.
    logic rr_lsu;

    logic not_full;
    logic contested;
    logic grant_alu;
    logic grant_lsu;
    logic acc_alu;
    logic acc_lsu;
    logic [4:0]  push_rd;
    logic [31:0] push_data;
    logic push;
    logic pop;

    assign not_full  = (fifo_count < CW'(DEPTH));
    assign contested = alu_valid && lsu_valid;
    assign grant_alu = alu_valid && (!lsu_valid || !rr_lsu);
    assign grant_lsu = lsu_valid && (!alu_valid || rr_lsu);

    // When the FIFO is full, both readies stay low even if a pop occurs this cycle.
    // This keeps ready free of any path from wb_hold.
    assign alu_ready = grant_alu && not_full;
    assign lsu_ready = grant_lsu && not_full;

    assign acc_alu   = alu_valid && alu_ready;
    assign acc_lsu   = lsu_valid && lsu_ready;
    assign push_rd   = acc_alu ? alu_rd   : lsu_rd;
    assign push_data = acc_alu ? alu_data : lsu_data;

    // A result for x0 completes its handshake but is dropped here.
    assign push = (acc_alu || acc_lsu) && (push_rd != 5'd0);
    assign pop  = (fifo_count != '0) && !wb_hold;

    // The pointer only moves when a contested grant actually transfers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_lsu <= 1'b0;
        end else if (contested && not_full) begin
            rr_lsu <= !rr_lsu;
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and the count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_rd[wr_ptr]   <= push_rd;
            mem_data[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // There is no bypass from push to the rf_* registers. An entry always spends one
    // cycle in the FIFO before it is written.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rf_write  <= 1'b0;
            rf_w_addr <= 5'd0;
            rf_w_data <= 32'd0;
        end else begin
            rf_write <= pop;
            if (pop) begin
                rf_w_addr <= mem_rd[rd_ptr];
                rf_w_data <= mem_data[rd_ptr];
            end
        end
    end

`ifdef WB_SCOREBOARD_EN
    logic [31:0] pending;
    logic [31:0] set_mask;
    logic [31:0] clr_mask;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (issue_valid && (issue_rd != 5'd0)) set_mask[issue_rd] = 1'b1;
        // The clear lands on the same edge the register file array updates.
        if (rf_write) clr_mask[rf_w_addr] = 1'b1;
    end

    // Set is applied after the clear, so a same-edge set and clear leaves the bit set.
    // Bit 0 is forced to 0.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pending <= '0;
        end else begin
            pending <= ((pending & ~clr_mask) | set_mask) & 32'hFFFF_FFFE;
        end
    end

    assign rs1_busy = pending[rs1_addr];
    assign rs2_busy = pending[rs2_addr];
`else
    logic unused_sb_inputs;
    assign unused_sb_inputs = ^{issue_valid, issue_rd, rs1_addr, rs2_addr};
    assign rs1_busy = 1'b0;
    assign rs2_busy = 1'b0;
`endif

endmodule

// File: tb/tb_wb_commit_unit.sv
// Directed bench for wb_commit_unit.
// Inputs are driven 1 time unit after the rising edge. Combinational readies are
// checked before the next edge. Register-file writes are compared in order against
// an expected queue at each falling edge.
module tb_wb_commit_unit;

    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clk;
    logic          rstn;
    logic          alu_valid;
    logic          alu_ready;
    logic [4:0]    alu_rd;
    logic [31:0]   alu_data;
    logic          lsu_valid;
    logic          lsu_ready;
    logic [4:0]    lsu_rd;
    logic [31:0]   lsu_data;
    logic          wb_hold;
    logic          issue_valid;
    logic [4:0]    issue_rd;
    logic [4:0]    rs1_addr;
    logic [4:0]    rs2_addr;
    logic          rs1_busy;
    logic          rs2_busy;
    logic          rf_write;
    logic [4:0]    rf_w_addr;
    logic [31:0]   rf_w_data;
    logic [CW-1:0] fifo_count;

    int n_checks = 0;
    int n_pass   = 0;

    // Expected register-file writes, {rd, data}, in commit order.
    logic [36:0] exp_q[$];

    wb_commit_unit #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .lsu_valid   (lsu_valid),
        .lsu_ready   (lsu_ready),
        .lsu_rd      (lsu_rd),
        .lsu_data    (lsu_data),
        .wb_hold     (wb_hold),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .rf_write    (rf_write),
        .rf_w_addr   (rf_w_addr),
        .rf_w_data   (rf_w_data),
        .fifo_count  (fifo_count)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compares every register-file write against the head of the expected queue.
    task automatic write_monitor();
        logic [36:0] e;
        forever begin
            @(negedge clk);
            if (rstn && rf_write) begin
                check("wr_expected", 64'(exp_q.size() > 0), 64'(1));
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("wr_addr", 64'(rf_w_addr), 64'(e[36:32]));
                    check("wr_data", 64'(rf_w_data), 64'(e[31:0]));
                end
            end
        end
    endtask

    task automatic drive_alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        alu_valid = v;
        alu_rd    = rd;
        alu_data  = d;
    endtask

    task automatic drive_lsu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        lsu_valid = v;
        lsu_rd    = rd;
        lsu_data  = d;
    endtask

    initial begin
        int ai;
        int li;
        logic exp_alu;

        // Reset
        rstn        = 1'b0;
        alu_valid   = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_valid   = 1'b0; lsu_rd = '0; lsu_data = '0;
        wb_hold     = 1'b0;
        issue_valid = 1'b0; issue_rd = '0;
        rs1_addr    = '0;   rs2_addr = '0;
        fork
            write_monitor();
        join_none
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        #1;
        check("rst_rf_write",  64'(rf_write),   64'(0));
        check("rst_rf_w_addr", 64'(rf_w_addr),  64'(0));
        check("rst_rf_w_data", 64'(rf_w_data),  64'(0));
        check("rst_count",     64'(fifo_count), 64'(0));
        check("rst_alu_ready", 64'(alu_ready),  64'(0));
        check("rst_busy",      64'({rs1_busy, rs2_busy}), 64'(0));

        // Single ALU result
        tick();
        drive_alu(1'b1, 5'd5, 32'hDEAD_BEEF);
        #1;
        check("t1_alu_ready", 64'(alu_ready), 64'(1));
        check("t1_lsu_ready", 64'(lsu_ready), 64'(0));
        exp_q.push_back({5'd5, 32'hDEAD_BEEF});
        tick();
        drive_alu(1'b0, 5'd0, 32'd0);
        check("t1_count_1", 64'(fifo_count), 64'(1));
        check("t1_no_write_yet", 64'(rf_write), 64'(0));
        tick();
        check("t1_rf_write", 64'(rf_write),  64'(1));
        check("t1_rf_addr",  64'(rf_w_addr), 64'(5));
        check("t1_rf_data",  64'(rf_w_data), 64'(32'hDEAD_BEEF));
        check("t1_count_0",  64'(fifo_count), 64'(0));
        tick();
        check("t1_write_done", 64'(rf_write), 64'(0));

        // Contested ALU/LSU: grants alternate starting with ALU
        ai = 0;
        li = 0;
        for (int c = 0; c < 8; c++) begin
            drive_alu(ai < 4, 5'(1 + ai),  32'hA000_0000 + 32'(1 + ai));
            drive_lsu(li < 4, 5'(11 + li), 32'hB000_0000 + 32'(11 + li));
            exp_alu = (c % 2 == 0);
            #1;
            check("t2_alu_ready", 64'(alu_ready), 64'(exp_alu));
            check("t2_lsu_ready", 64'(lsu_ready), 64'(!exp_alu));
            if (exp_alu) begin
                exp_q.push_back({5'(1 + ai), 32'hA000_0000 + 32'(1 + ai)});
                ai++;
            end else begin
                exp_q.push_back({5'(11 + li), 32'hB000_0000 + 32'(11 + li)});
                li++;
            end
            tick();
            // Accept one and pop one per cycle, so at most one entry is ever buffered.
            check("t2_count", 64'(fifo_count), 64'(1));
        end
        drive_alu(1'b0, 5'd0, 32'd0);
        drive_lsu(1'b0, 5'd0, 32'd0);
        repeat (3) tick();
        check("t2_all_written", 64'(exp_q.size()), 64'(0));
        check("t2_count_0", 64'(fifo_count), 64'(0));

        // wb_hold fills the FIFO; the 5th result waits for the drain
        wb_hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_alu(1'b1, 5'(20 + i), 32'hC000_0000 + 32'(i));
            #1;
            check("t3_ready_fill", 64'(alu_ready), 64'(1));
            exp_q.push_back({5'(20 + i), 32'hC000_0000 + 32'(i)});
            tick();
            check("t3_hold_no_write", 64'(rf_write), 64'(0));
            check("t3_count_fill", 64'(fifo_count), 64'(i + 1));
        end
        drive_alu(1'b1, 5'd24, 32'hC000_0004);
        #1;
        check("t3_ready_full", 64'(alu_ready), 64'(0));
        check("t3_count_full", 64'(fifo_count), 64'(4));
        tick();
        check("t3_ready_full2", 64'(alu_ready), 64'(0));
        check("t3_hold_no_write2", 64'(rf_write), 64'(0));
        wb_hold = 1'b0;
        #1;
        // A pop happens on the next edge, but the full FIFO still blocks acceptance.
        check("t3_ready_full_pop", 64'(alu_ready), 64'(0));
        tick();
        check("t3_drain_write", 64'(rf_write),   64'(1));
        check("t3_drain_addr",  64'(rf_w_addr),  64'(20));
        check("t3_count_3",     64'(fifo_count), 64'(3));
        check("t3_ready_after", 64'(alu_ready),  64'(1));
        exp_q.push_back({5'd24, 32'hC000_0004});
        tick();
        drive_alu(1'b0, 5'd0, 32'd0);
        check("t3_count_pushpop", 64'(fifo_count), 64'(3));
        repeat (5) tick();
        check("t3_all_written", 64'(exp_q.size()), 64'(0));
        check("t3_count_0", 64'(fifo_count), 64'(0));

        // x0 filter
        drive_lsu(1'b1, 5'd0, 32'h0000_1234);
        #1;
        check("t4_lsu_ready", 64'(lsu_ready), 64'(1));
        tick();
        drive_lsu(1'b0, 5'd0, 32'd0);
        check("t4_count", 64'(fifo_count), 64'(0));
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_no_write", 64'(rf_write), 64'(0));
        end

        // Scoreboard set / clear / set-wins
        rs1_addr = 5'd7;
        rs2_addr = 5'd8;
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        tick();
        issue_valid = 1'b0;
`ifdef WB_SCOREBOARD_EN
        check("t5_rs1_busy_set", 64'(rs1_busy), 64'(1));
`else
        check("t5_rs1_busy_off", 64'(rs1_busy), 64'(0));
`endif
        check("t5_rs2_idle", 64'(rs2_busy), 64'(0));
        drive_alu(1'b1, 5'd7, 32'h0000_0077);
        exp_q.push_back({5'd7, 32'h0000_0077});
        tick();
        drive_alu(1'b0, 5'd0, 32'd0);
        tick();
        check("t5_write7", 64'(rf_write), 64'(1));
`ifdef WB_SCOREBOARD_EN
        check("t5_busy_until_write", 64'(rs1_busy), 64'(1));
`endif
        tick();
        check("t5_rs1_cleared", 64'(rs1_busy), 64'(0));
        // Reissue rd=7 and land the issue on the clearing edge.
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        tick();
        issue_valid = 1'b0;
        drive_alu(1'b1, 5'd7, 32'h0000_0078);
        exp_q.push_back({5'd7, 32'h0000_0078});
        tick();
        drive_alu(1'b0, 5'd0, 32'd0);
        tick();
        check("t5_write7b", 64'(rf_write), 64'(1));
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        tick();
        issue_valid = 1'b0;
        check("t5_write7b_done", 64'(rf_write), 64'(0));
`ifdef WB_SCOREBOARD_EN
        check("t5_set_wins", 64'(rs1_busy), 64'(1));
`else
        check("t5_set_wins_off", 64'(rs1_busy), 64'(0));
`endif
        rs2_addr = 5'd0;
        #1;
        check("t5_x0_never_busy", 64'(rs2_busy), 64'(0));

        // Reset with 3 entries queued and 2 bits pending
        wb_hold  = 1'b1;
        rs1_addr = 5'd9;
        rs2_addr = 5'd10;
        for (int i = 0; i < 3; i++) begin
            drive_alu(1'b1, 5'(25 + i), 32'hD000_0000 + 32'(i));
            issue_valid = (i < 2);
            issue_rd    = 5'(9 + i);
            tick();
        end
        drive_alu(1'b0, 5'd0, 32'd0);
        issue_valid = 1'b0;
        check("t6_count_3", 64'(fifo_count), 64'(3));
`ifdef WB_SCOREBOARD_EN
        check("t6_pending", 64'({rs1_busy, rs2_busy}), 64'(3));
`else
        check("t6_pending_off", 64'({rs1_busy, rs2_busy}), 64'(0));
`endif
        rstn = 1'b0;
        #1;
        check("t6_rst_write", 64'(rf_write),   64'(0));
        check("t6_rst_addr",  64'(rf_w_addr),  64'(0));
        check("t6_rst_data",  64'(rf_w_data),  64'(0));
        check("t6_rst_count", 64'(fifo_count), 64'(0));
        check("t6_rst_busy",  64'({rs1_busy, rs2_busy}), 64'(0));
        wb_hold = 1'b0;
        tick();
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t6_no_write", 64'(rf_write), 64'(0));
            check("t6_count_0",  64'(fifo_count), 64'(0));
        end
        check("end_queue_empty", 64'(exp_q.size()), 64'(0));

        // Final report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
